// File: rtl/seq_1100_pkg.sv
// seq_1100_pkg: shared types and constants for the 1100 pattern generator.
//   state_e        generator FSM states
//   det_e          states of the optional 1100 Moore detector
//   LIT_*          active-low 7-segment codes shown on st_literal
//   PATTERN_1100   the pattern that the optional self-check understands
package seq_1100_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    DET_0,
    DET_1,
    DET_11,
    DET_110,
    DET_1100
  } det_e;

  localparam logic [7:0] LIT_IDLE = 8'hC0;
  localparam logic [7:0] LIT_SEND = 8'h92;
  localparam logic [7:0] LIT_GAP  = 8'hC2;
  localparam logic [7:0] LIT_DONE = 8'hA1;

  localparam logic [3:0] PATTERN_1100 = 4'b1100;

  function automatic logic [7:0] state_literal(input state_e s);
    case (s)
      SEND:    return LIT_SEND;
      GAP:     return LIT_GAP;
      DONE:    return LIT_DONE;
      default: return LIT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/seq_1100_chk.sv
// seq_1100_chk: Moore 1100 detector with a saturating hit counter.
// Only instantiated when SEQ_1100_GEN_SELF_CHECK_EN is defined.
//   clk_i    system clock, rising edge
//   rst_i    synchronous active-high reset
//   clr_i    clears detector and hit count (frame start)
//   x_i      serial bit under observation
//   valid_i  x_i carries a meaningful bit this cycle
//   hits_o   number of 1100 occurrences since the last clear
module seq_1100_chk
  import seq_1100_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             x_i,
  input  logic             valid_i,
  output logic [CNT_W-1:0] hits_o
);

  det_e             det_q, det_d;
  logic [CNT_W-1:0] hits_q;

  always_comb begin
    det_d = det_q;
    if (valid_i) begin
      case (det_q)
        DET_0:    det_d = x_i ? DET_1  : DET_0;
        DET_1:    det_d = x_i ? DET_11 : DET_0;
        DET_11:   det_d = x_i ? DET_11 : DET_110;
        DET_110:  det_d = x_i ? DET_1  : DET_1100;
        DET_1100: det_d = x_i ? DET_1  : DET_0;
        default:  det_d = DET_0;
      endcase
    end
  end

  // A hit is counted on entry to DET_1100 so the count is final the
  // cycle after the last pattern bit is observed.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      det_q  <= DET_0;
      hits_q <= '0;
    end else begin
      det_q <= det_d;
      if (valid_i && det_d == DET_1100 && hits_q != '1)
        hits_q <= hits_q + CNT_W'(1);
    end
  end

  assign hits_o = hits_q;

endmodule

// File: rtl/seq_1100_gen.sv
// seq_1100_gen: serial pattern transmitter feeding the 1100 detector.
// Sends a latched PAT_W-bit pattern MSB-first, repeat_n times, separated by
// gap_len zero bits. Optional self-check: SEQ_1100_GEN_SELF_CHECK_EN.
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        launch request, sampled only in IDLE
//   pattern_in_i   pattern, latched on accepted start
//   repeat_n_i     repetitions, latched on accepted start
//   gap_len_i      zero bits between repetitions, latched on accepted start
//   x_out_o        serial data
//   x_valid_o      x_out_o carries a pattern or gap bit
//   busy_o         FSM not idle
//   done_o         one-cycle end-of-frame pulse
//   err_o          self-check mismatch (tied 0 without the macro)
//   st_literal_o   active-low 7-segment code of the state
//
// state | meaning
// IDLE  | waiting for start
// SEND  | shifting pattern bit idx
// GAP   | emitting zero gap bits
// DONE  | frame complete, one cycle
//
// Every output is a register loaded from the FSM state of the previous
// cycle, so the first pattern bit appears one cycle after the start edge.
module seq_1100_gen
  import seq_1100_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [PAT_W-1:0] pattern_in_i,
  input  logic [CNT_W-1:0] repeat_n_i,
  input  logic [GAP_W-1:0] gap_len_i,
  output logic             x_out_o,
  output logic             x_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [7:0]       st_literal_o
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] rep_q, rep_n_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_len_q;
  logic [PAT_W-1:0] pat_q;
  logic             x_out_q, x_valid_q, busy_q, done_q;
  logic [7:0]       lit_q;
  logic             start_acc;

  always_comb begin
    start_acc = (state_q == IDLE) && start_i;
    rep_d     = rep_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rep_q     <= '0;
      rep_n_q   <= '0;
      gap_q     <= '0;
      gap_len_q <= '0;
      pat_q     <= '0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lit_q     <= LIT_IDLE;
    end else begin
      x_out_q   <= (state_q == SEND) ? pat_q[idx_q] : 1'b0;
      x_valid_q <= (state_q == SEND) || (state_q == GAP);
      busy_q    <= (state_q != IDLE);
      done_q    <= (state_q == DONE);
      lit_q     <= state_literal(state_q);

      case (state_q)
        IDLE: begin
          if (start_i) begin
            pat_q     <= pattern_in_i;
            rep_n_q   <= repeat_n_i;
            gap_len_q <= gap_len_i;
            rep_q     <= '0;
            idx_q     <= IDX_LAST;
            state_q   <= (repeat_n_i == '0) ? DONE : SEND;
          end
        end
        SEND: begin
          if (idx_q == '0) begin
            rep_q <= rep_d;
            if (rep_d == rep_n_q) begin
              state_q <= DONE;
            end else if (gap_len_q != '0) begin
              gap_q   <= gap_len_q;
              state_q <= GAP;
            end else begin
              idx_q <= IDX_LAST;
            end
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        GAP: begin
          gap_q <= gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) begin
            idx_q   <= IDX_LAST;
            state_q <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_out_o      = x_out_q;
  assign x_valid_o    = x_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign st_literal_o = lit_q;

`ifdef SEQ_1100_GEN_SELF_CHECK_EN
  logic [CNT_W-1:0] hits;
  logic             err_q;

  // The detector watches the registered serial stream exactly as an
  // external detector would see it.
  seq_1100_chk #(
    .CNT_W (CNT_W)
  ) u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (start_acc),
    .x_i     (x_out_q),
    .valid_i (x_valid_q),
    .hits_o  (hits)
  );

  // Checked while done_o is high: by then the final pattern bit has been
  // consumed by the detector.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_acc)
      err_q <= 1'b0;
    else if (done_q && (PAT_W == 4) && (pat_q == PAT_W'(PATTERN_1100))
             && (hits != rep_n_q))
      err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
